// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared 8N1 frame constants and serializer state encoding.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Bundle of N_REQ byte-stream requester channels (valid/ready/last).
// Revision : 1.0
// ============================================================================
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]                req_valid;
    logic [N_REQ*UART_DATA_BITS-1:0] req_data;
    logic [N_REQ-1:0]                req_last;
    logic [N_REQ-1:0]                req_ready;

    modport master (output req_valid, output req_data, output req_last, input  req_ready);
    modport slave  (input  req_valid, input  req_data, input  req_last, output req_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : 8N1 frame shifter, CLK_SAMPLES clocks per bit, reloadable in STOP.
// Revision : 1.0
// ============================================================================
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_SAMPLES = 4
)(
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      load,
    input  wire logic [UART_DATA_BITS-1:0] data,
    output logic                           tx,
    output logic                           idle,
    output logic                           last_stop_cycle
);
    localparam int            SW          = (CLK_SAMPLES > 1) ? $clog2(CLK_SAMPLES) : 1;
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(CLK_SAMPLES - 1);

    uart_tx_state_e            state_q, state_d;
    logic [SW-1:0]             sample_q, sample_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      sample_wrap;

    assign sample_wrap = (sample_q == SAMPLE_LAST);

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        bit_d    = bit_q;
        data_d   = data_q;
        if (state_q != IDLE) begin
            sample_d = sample_wrap ? '0 : sample_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d  = START;
                    data_d   = data;
                    sample_d = '0;
                    bit_d    = '0;
                end
            end
            START: if (sample_wrap) state_d = DATA;
            DATA: begin
                if (sample_wrap) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Reload here gives back-to-back frames with no idle gap
                if (sample_wrap) begin
                    if (load) begin
                        state_d = START;
                        data_d  = data;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sample_q <= '0;
            bit_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        case (state_q)
            START:   tx = UART_START_BIT;
            DATA:    tx = data_q[bit_q];
            default: tx = UART_STOP_BIT;
        endcase
    end

    assign idle            = (state_q == IDLE);
    assign last_stop_cycle = (state_q == STOP) && sample_wrap;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Message-granular round-robin sharing of one 8N1 UART tx line.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int CLK_SAMPLES = 4
)(
    input  wire logic               clk,
    input  wire logic               rst_n,
    uart_tx_arbiter_if.slave        req,
    output logic                    tx,
    output logic                    busy,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);
    localparam int               IDX_W    = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    logic                      locked_q, locked_d;
    logic [IDX_W-1:0]          owner_q, owner_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]          winner, cand, sel;
    logic                      found, window, accept;
    logic                      ser_idle, ser_last_stop;
    logic [N_REQ-1:0]          ready;
    logic [UART_DATA_BITS-1:0] sel_data;
    logic                      sel_last;

    // Descending scan so the candidate closest to rr_ptr is written last
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        cand   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (req.req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign sel    = locked_q ? owner_q : winner;
    assign window = ser_idle | ser_last_stop;

    always_comb begin
        ready = '0;
        if (rst_n && window && (locked_q || found)) begin
            ready[sel] = 1'b1;
        end
    end

    assign req.req_ready = ready;
    assign accept        = |(ready & req.req_valid);
    assign sel_data      = req.req_data[{sel, 3'b000} +: UART_DATA_BITS];
    assign sel_last      = req.req_last[sel];

    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            owner_d = sel;
            if (sel_last) begin
                locked_d = 1'b0;
                rr_ptr_d = (sel == LAST_IDX) ? '0 : sel + 1'b1;
            end else begin
                locked_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q <= 1'b0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    uart_tx_serializer #(
        .CLK_SAMPLES (CLK_SAMPLES)
    ) u_ser (
        .clk             (clk),
        .rst_n           (rst_n),
        .load            (accept),
        .data            (sel_data),
        .tx              (tx),
        .idle            (ser_idle),
        .last_stop_cycle (ser_last_stop)
    );

    assign busy      = locked_q | ~ser_idle;
    assign grant_idx = owner_q;

endmodule
`default_nettype wire
